// File: rtl/k6502_pkg.sv
// ---------------------------------------------------------------------------
// k6502_pkg
// Shared types and constants for the k6502 cycle sequencer:
//   control_signals_t : packed 16-bit datapath control bundle
//   OP_*              : opcodes understood by the sequencer
//   seq_state_t       : sequencer states
//   addr_class_t      : addressing class produced by the opcode decoder
//   seq_out_t         : every registered sequencer output in one bundle
// Related build option: K6502_SEQ_STEP_EN (single-step halt, see k6502_seq).
// ---------------------------------------------------------------------------
package k6502_pkg;

    // Field order is fixed: the first field is bit 15 of the packed bus.
    typedef struct packed {
        logic ac_db;
        logic ac_sb;
        logic add_adl;
        logic add_sb06;
        logic add_sb7;
        logic adh_abh;
        logic adl_abl;
        logic dl_adh;
        logic dl_adl;
        logic dl_db;
        logic sb_add;
        logic sb_x;
        logic sb_y;
        logic x_sb;
        logic y_sb;
        logic z_add;
    } control_signals_t;

    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_LDX_ZP  = 8'hA6;
    localparam logic [7:0] OP_LDY_ZP  = 8'hA4;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    typedef enum logic [2:0] {RST_WAIT, T0, T1, T2, JAM} seq_state_t;

    typedef enum logic [1:0] {AC_IMM, AC_ZP, AC_IMPL, AC_ILLEGAL} addr_class_t;

    // tstate value reported while idle, halted or jammed.
    localparam logic [2:0] TSTATE_IDLE = 3'd7;

    typedef struct packed {
        control_signals_t ctl;
        logic             pc_abus;
        logic             pc_inc;
        logic             zero_adh;
        logic             sb_db;
        logic             sync;
        logic             jam;
        logic [2:0]       tstate;
    } seq_out_t;

    // Output bundle with every strobe low and tstate reporting idle.
    function automatic seq_out_t idle_out();
        seq_out_t o;
        o        = '0;
        o.tstate = TSTATE_IDLE;
        return o;
    endfunction

endpackage

// File: rtl/k6502_decode.sv
// ---------------------------------------------------------------------------
// k6502_decode
// Combinational opcode classifier. New opcodes are added here only; the
// sequencer FSM consumes the class and never looks at raw opcode bits.
// Ports:
//   pd          in  8  opcode from the pre-decode register
//   addr_class  out 2  addressing class (AC_ILLEGAL for anything unknown)
//   target_is_y out 1  load target is Y (else X)
// ---------------------------------------------------------------------------
module k6502_decode
    import k6502_pkg::*;
(
    input  logic [7:0]  pd,
    output addr_class_t addr_class,
    output logic        target_is_y
);

    always_comb begin
        // NOTE: every output gets a default before the case so that opcodes
        // not listed below cannot leave a value held, which would infer a latch.
        addr_class  = AC_ILLEGAL;
        target_is_y = 1'b0;
        case (pd)
            OP_LDX_IMM: addr_class = AC_IMM;
            OP_LDY_IMM: begin
                addr_class  = AC_IMM;
                target_is_y = 1'b1;
            end
            OP_LDX_ZP:  addr_class = AC_ZP;
            OP_LDY_ZP:  begin
                addr_class  = AC_ZP;
                target_is_y = 1'b1;
            end
            OP_NOP:     addr_class = AC_IMPL;
            default:    ;
        endcase
    end

endmodule

// File: rtl/k6502_seq.sv
// ---------------------------------------------------------------------------
// k6502_seq
// Cycle sequencer for the k6502 datapath, one T-state per ph0 cycle.
// Register write-back of a load overlaps the following opcode fetch (T0).
// All outputs are registered: the value shown in a cycle was computed at the
// edge that entered that cycle.
// Ports:
//   ph0      in   1  clock
//   reset    in   1  synchronous active-high reset
//   rdy      in   1  memory ready; low stalls T0/T1/T2
//   step     in   1  single-step release (only with K6502_SEQ_STEP_EN)
//   pd       in   8  opcode from the pre-decode register
//   ctl      out 16  control_signals_t, packed
//   pc_abus  out  1  external PC drives ADL/ADH
//   pc_inc   out  1  external PC increments at the end of this cycle
//   zero_adh out  1  drive 0x00 onto ADH
//   sb_db    out  1  SB/DB pass gate closed
//   sync     out  1  opcode-fetch T0
//   tstate   out  3  0..2, or 7 when idle/halted/jammed
//   jam      out  1  illegal opcode latched
// Build option K6502_SEQ_STEP_EN: adds the step input; the sequencer halts
// at each T0 boundary until a cycle with step=1, then runs one instruction.
// ---------------------------------------------------------------------------
module k6502_seq
    import k6502_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 2   // 1..7
) (
    input  logic        ph0,
    input  logic        reset,
    input  logic        rdy,
`ifdef K6502_SEQ_STEP_EN
    input  logic        step,
`endif
    input  logic [7:0]  pd,
    output logic [15:0] ctl,
    output logic        pc_abus,
    output logic        pc_inc,
    output logic        zero_adh,
    output logic        sb_db,
    output logic        sync,
    output logic [2:0]  tstate,
    output logic        jam
);

    seq_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    addr_class_t cls_q, cls_d;
    logic        tgt_y_q, tgt_y_d;
    logic        pend_q, pend_d;
    logic        pend_y_q, pend_y_d;
    seq_out_t    out_q, out_d;
    logic        halt_d;
    logic        stall;

    addr_class_t dec_class;
    logic        dec_y;

`ifdef K6502_SEQ_STEP_EN
    localparam logic STEP_EN = 1'b1;
    logic halt_q;
    logic halted;
    logic step_in;
    assign halted  = halt_q;
    assign step_in = step;
`else
    localparam logic STEP_EN = 1'b0;
    logic halted;
    logic step_in;
    assign halted  = 1'b0;
    assign step_in = 1'b0;
`endif

    k6502_decode u_decode (
        .pd          (pd),
        .addr_class  (dec_class),
        .target_is_y (dec_y)
    );

    // Strobes for a given state. The pending write-back rides on the fetch.
    function automatic seq_out_t outputs_for(input seq_state_t  st,
                                             input addr_class_t cls,
                                             input logic        pend,
                                             input logic        pend_y,
                                             input logic        hold);
        seq_out_t o;
        o = idle_out();
        if (!hold) begin
            case (st)
                T0: begin
                    o.tstate      = 3'd0;
                    o.sync        = 1'b1;
                    o.pc_abus     = 1'b1;
                    o.pc_inc      = 1'b1;
                    o.ctl.adl_abl = 1'b1;
                    o.ctl.adh_abh = 1'b1;
                    if (pend) begin
                        o.ctl.dl_db = 1'b1;
                        o.sb_db     = 1'b1;
                        o.ctl.sb_y  = pend_y;
                        o.ctl.sb_x  = !pend_y;
                    end
                end
                T1: begin
                    o.tstate = 3'd1;
                    if (cls != AC_ILLEGAL) begin
                        o.pc_abus     = 1'b1;
                        o.ctl.adl_abl = 1'b1;
                        o.ctl.adh_abh = 1'b1;
                        // NOP performs a dummy read without consuming a byte.
                        o.pc_inc      = (cls == AC_IMM) || (cls == AC_ZP);
                    end
                end
                T2: begin
                    o.tstate      = 3'd2;
                    o.ctl.dl_adl  = 1'b1;
                    o.ctl.adl_abl = 1'b1;
                    o.zero_adh    = 1'b1;
                    o.ctl.adh_abh = 1'b1;
                end
                JAM:     o.jam = 1'b1;
                default: ;
            endcase
        end
        return o;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cls_d    = cls_q;
        tgt_y_d  = tgt_y_q;
        pend_d   = pend_q;
        pend_y_d = pend_y_q;
        halt_d   = halted;
        stall    = 1'b0;

        case (state_q)
            RST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = T0;
                end
            end
            T0: begin
                if (halted) begin
                    halt_d = !step_in;
                end else if (!rdy) begin
                    stall = 1'b1;
                end else begin
                    // The opcode is latched on leaving T0 so T1's registered
                    // strobes can already depend on it.
                    state_d = T1;
                    pend_d  = 1'b0;
                    cls_d   = dec_class;
                    tgt_y_d = dec_y;
                end
            end
            T1: begin
                if (!rdy) begin
                    stall = 1'b1;
                end else begin
                    case (cls_q)
                        AC_IMM: begin
                            pend_d   = 1'b1;
                            pend_y_d = tgt_y_q;
                            state_d  = T0;
                        end
                        AC_ZP:   state_d = T2;
                        AC_IMPL: state_d = T0;
                        default: state_d = JAM;
                    endcase
                end
            end
            T2: begin
                if (!rdy) begin
                    stall = 1'b1;
                end else begin
                    pend_d   = 1'b1;
                    pend_y_d = tgt_y_q;
                    state_d  = T0;
                end
            end
            JAM:     ;
            default: state_d = JAM;
        endcase

        // Every fresh arrival at a T0 boundary halts when stepping is built in.
        if (STEP_EN && (state_d == T0) && (state_q != T0)) begin
            halt_d = 1'b1;
        end

        // A stalled cycle repeats its strobes, but the PC must not advance again.
        if (stall) begin
            out_d        = out_q;
            out_d.pc_inc = 1'b0;
        end else begin
            out_d = outputs_for(state_d, cls_d, pend_d, pend_y_d, halt_d);
        end
    end

    always_ff @(posedge ph0) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q  <= RST_WAIT;
            cnt_q    <= 3'(RESET_HOLD);
            cls_q    <= AC_ILLEGAL;
            tgt_y_q  <= 1'b0;
            pend_q   <= 1'b0;
            pend_y_q <= 1'b0;
            out_q    <= idle_out();
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cls_q    <= cls_d;
            tgt_y_q  <= tgt_y_d;
            pend_q   <= pend_d;
            pend_y_q <= pend_y_d;
            out_q    <= out_d;
        end
    end

`ifdef K6502_SEQ_STEP_EN
    always_ff @(posedge ph0) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    assign ctl      = out_q.ctl;
    assign pc_abus  = out_q.pc_abus;
    assign pc_inc   = out_q.pc_inc;
    assign zero_adh = out_q.zero_adh;
    assign sb_db    = out_q.sb_db;
    assign sync     = out_q.sync;
    assign tstate   = out_q.tstate;
    assign jam      = out_q.jam;

    // Bus-contention invariants on the registered strobes.
    a_xsb_sbx:   assert property (@(posedge ph0) !(out_q.ctl.x_sb && out_q.ctl.sb_x));
    a_sbx_sby:   assert property (@(posedge ph0) !(out_q.ctl.sb_x && out_q.ctl.sb_y));
    a_pc_dladl:  assert property (@(posedge ph0) !(out_q.pc_abus && out_q.ctl.dl_adl));
    a_zadh_pc:   assert property (@(posedge ph0) !(out_q.zero_adh && out_q.pc_abus));

endmodule

// File: tb/tb_k6502_seq.sv
// ---------------------------------------------------------------------------
// tb_k6502_seq
// Self-checking bench for k6502_seq (default build). A driver issues whole
// instructions (with optional rdy stalls and reset aborts) and pushes the
// expected output record of every cycle into a queue; a monitor pops one
// record per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_k6502_seq;
    import k6502_pkg::*;

    localparam int unsigned HOLD = 2;

    logic        ph0   = 1'b0;
    logic        reset = 1'b1;
    logic        rdy   = 1'b1;
    logic [7:0]  pd    = 8'h00;
    logic [15:0] ctl;
    logic        pc_abus, pc_inc, zero_adh, sb_db, sync, jam;
    logic [2:0]  tstate;

    k6502_seq #(.RESET_HOLD(HOLD)) dut (
        .ph0      (ph0),
        .reset    (reset),
        .rdy      (rdy),
        .pd       (pd),
        .ctl      (ctl),
        .pc_abus  (pc_abus),
        .pc_inc   (pc_inc),
        .zero_adh (zero_adh),
        .sb_db    (sb_db),
        .sync     (sync),
        .tstate   (tstate),
        .jam      (jam)
    );

    always #5 ph0 = ~ph0;

    typedef struct packed {
        control_signals_t ctl;
        logic             pc_abus;
        logic             pc_inc;
        logic             zero_adh;
        logic             sb_db;
        logic             sync;
        logic             jam;
        logic [2:0]       tstate;
    } obs_t;

    typedef enum {K_IMM, K_ZP, K_NOP, K_BAD} kind_e;

    obs_t expq[$];
    obs_t cur;
    obs_t mon_exp, mon_act;
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- reference model: one record per bus cycle -------------
    function automatic kind_e kind_of(input logic [7:0] op);
        case (op)
            8'hA2, 8'hA0: return K_IMM;
            8'hA6, 8'hA4: return K_ZP;
            8'hEA:        return K_NOP;
            default:      return K_BAD;
        endcase
    endfunction

    function automatic obs_t idle_rec();
        obs_t o = '0;
        o.tstate = 3'd7;
        return o;
    endfunction

    function automatic obs_t fetch_rec(input logic wb, input logic wb_y);
        obs_t o = '0;
        o.tstate      = 3'd0;
        o.sync        = 1'b1;
        o.pc_abus     = 1'b1;
        o.pc_inc      = 1'b1;
        o.ctl.adl_abl = 1'b1;
        o.ctl.adh_abh = 1'b1;
        if (wb) begin
            o.ctl.dl_db = 1'b1;
            o.sb_db     = 1'b1;
            if (wb_y) o.ctl.sb_y = 1'b1;
            else      o.ctl.sb_x = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t operand_rec(input logic inc);
        obs_t o = '0;
        o.tstate      = 3'd1;
        o.pc_abus     = 1'b1;
        o.pc_inc      = inc;
        o.ctl.adl_abl = 1'b1;
        o.ctl.adh_abh = 1'b1;
        return o;
    endfunction

    function automatic obs_t zp_rec();
        obs_t o = '0;
        o.tstate      = 3'd2;
        o.ctl.dl_adl  = 1'b1;
        o.ctl.adl_abl = 1'b1;
        o.zero_adh    = 1'b1;
        o.ctl.adh_abh = 1'b1;
        return o;
    endfunction

    function automatic obs_t bad_t1_rec();
        obs_t o = '0;
        o.tstate = 3'd1;
        return o;
    endfunction

    function automatic obs_t jam_rec();
        obs_t o = '0;
        o.tstate = 3'd7;
        o.jam    = 1'b1;
        return o;
    endfunction

    function automatic obs_t stalled(input obs_t o);
        obs_t s = o;
        s.pc_inc = 1'b0;
        return s;
    endfunction

    function automatic int rnd_stall();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got ctl=%h abus=%b inc=%b zadh=%b sbdb=%b sync=%b jam=%b ts=%0d, want ctl=%h abus=%b inc=%b zadh=%b sbdb=%b sync=%b jam=%b ts=%0d",
                     name, $time,
                     act.ctl, act.pc_abus, act.pc_inc, act.zero_adh, act.sb_db, act.sync, act.jam, act.tstate,
                     exp.ctl, exp.pc_abus, exp.pc_inc, exp.zero_adh, exp.sb_db, exp.sync, exp.jam, exp.tstate);
        end
    endtask

    always @(negedge ph0) begin
        if (expq.size() > 0) begin
            mon_exp          = expq.pop_front();
            mon_act.ctl      = ctl;
            mon_act.pc_abus  = pc_abus;
            mon_act.pc_inc   = pc_inc;
            mon_act.zero_adh = zero_adh;
            mon_act.sb_db    = sb_db;
            mon_act.sync     = sync;
            mon_act.jam      = jam;
            mon_act.tstate   = tstate;
            check("cycle", mon_act, mon_exp);
        end
    end

    // ---------------- stimulus ----------------
    // Drive inputs for the next edge; nxt is what the cycle after it must show.
    task automatic advance(input logic r, input logic rd, input logic [7:0] p, input obs_t nxt);
        reset = r;
        rdy   = rd;
        pd    = p;
        @(posedge ph0);
        expq.push_back(nxt);
        cur = nxt;
        #1;
    endtask

    // Move to cycle b after 'stalls' rdy-low repeats of the current cycle.
    task automatic goto(input obs_t b, input logic [7:0] p, input int stalls);
        repeat (stalls) advance(1'b0, 1'b0, p, stalled(cur));
        advance(1'b0, 1'b1, p, b);
    endtask

    // Reset for n cycles, sit out the hold time (rdy is don't-care), land in T0.
    task automatic do_reset(input int n);
        repeat (n) advance(1'b1, 1'($urandom), 8'($urandom), idle_rec());
        repeat (HOLD - 1) advance(1'b0, 1'($urandom), 8'($urandom), idle_rec());
        advance(1'b0, 1'($urandom), 8'($urandom), fetch_rec(1'b0, 1'b0));
    endtask

    // Starts in T0 of op, ends in the following T0. abort_at 1/2 asserts
    // reset while in T1/T2 instead of continuing.
    task automatic run_instr(input logic [7:0] op, input int s1, input int s2,
                             input int s3, input int abort_at);
        kind_e k;
        logic  y;
        k = kind_of(op);
        y = (op == 8'hA0) || (op == 8'hA4);
        case (k)
            K_BAD: begin
                goto(bad_t1_rec(), op, s1);
                goto(jam_rec(), op, s2);
                repeat (9) advance(1'b0, 1'($urandom), 8'($urandom), jam_rec());
                do_reset(2);
            end
            K_NOP: begin
                goto(operand_rec(1'b0), op, s1);
                if (abort_at == 1) begin do_reset(1 + rnd_stall()); return; end
                goto(fetch_rec(1'b0, 1'b0), op, s2);
            end
            K_IMM: begin
                goto(operand_rec(1'b1), op, s1);
                if (abort_at == 1) begin do_reset(1 + rnd_stall()); return; end
                goto(fetch_rec(1'b1, y), op, s2);
            end
            default: begin
                goto(operand_rec(1'b1), op, s1);
                if (abort_at == 1) begin do_reset(1 + rnd_stall()); return; end
                goto(zp_rec(), op, s2);
                if (abort_at == 2) begin do_reset(1 + rnd_stall()); return; end
                goto(fetch_rec(1'b1, y), 8'($urandom), s3);
            end
        endcase
    endtask

    logic [7:0] legal [5] = '{8'hA2, 8'hA0, 8'hA6, 8'hA4, 8'hEA};

    initial begin
        cur = idle_rec();
        do_reset(3);
        run_instr(8'hA2, 0, 0, 0, -1);   // LDX #: 2 cycles, X loaded in next T0
        run_instr(8'hA4, 0, 0, 0, -1);   // LDY zp: 3 cycles, Y loaded in next T0
        run_instr(8'hA6, 0, 0, 3, -1);   // rdy low for 3 cycles in T2
        run_instr(8'hA0, 2, 1, 0, -1);   // stall in a write-back T0 and in T1
        run_instr(8'hEA, 0, 1, 0, -1);   // NOP: dummy read, no pc_inc
        run_instr(8'hA6, 0, 0, 0, 2);    // reset in T2 drops the write-back
        run_instr(8'h00, 0, 0, 0, -1);   // illegal opcode jams until reset

        for (int n = 0; n < 300; n++) begin
            logic [7:0] op;
            int         ab;
            if ($urandom_range(0, 15) == 0) begin
                op = 8'($urandom);
                while (kind_of(op) != K_BAD) op = 8'($urandom);
            end else begin
                op = legal[$urandom_range(0, 4)];
            end
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : -1;
            run_instr(op, rnd_stall(), rnd_stall(), rnd_stall(), ab);
        end

        @(negedge ph0);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
